// File: rtl/conv2d_strided_mc.sv
// Streaming KxK convolution over a raster pixel stream: one shared sliding window,
// several output channels, output stride, optional saturation and end-of-frame flag.
module conv2d_strided_mc #(
  parameter int LineWidthPx = 160,
  parameter int LineCountPx = 120,
  parameter int WidthIn     = 1,
  parameter int WidthOut    = 32,
  parameter int KernelWidth = 3,
  parameter int WeightWidth = 2,
  parameter int OutChannels = 2,
  parameter int Stride      = 1,
  parameter int Saturate    = 0
) (
  input  logic                                                           clk_i,
  input  logic                                                           rst_i,
  input  logic                                                           valid_i,
  output logic                                                           ready_o,
  input  logic [WidthIn-1:0]                                             data_i,
  input  logic [OutChannels-1:0][KernelWidth*KernelWidth-1:0][WeightWidth-1:0] weights_i,
  output logic                                                           valid_o,
  input  logic                                                           ready_i,
  output logic [OutChannels-1:0][WidthOut-1:0]                           data_o,
  output logic                                                           last_o
);
  localparam int KernelArea = KernelWidth * KernelWidth;
  localparam int acc_w  = WidthOut + $clog2(KernelArea) + WidthIn + WeightWidth;
  localparam int xw     = (LineWidthPx > 1) ? $clog2(LineWidthPx) : 1;
  localparam int yw     = (LineCountPx > 1) ? $clog2(LineCountPx) : 1;
  localparam int sw     = (Stride > 1) ? $clog2(Stride) : 1;
  localparam int last_x = KernelWidth - 1 + ((LineWidthPx - KernelWidth) / Stride) * Stride;
  localparam int last_y = KernelWidth - 1 + ((LineCountPx - KernelWidth) / Stride) * Stride;
  localparam logic signed [acc_w-1:0] sat_max = {{(acc_w-WidthOut+1){1'b0}}, {(WidthOut-1){1'b1}}};
  localparam logic signed [acc_w-1:0] sat_min = {{(acc_w-WidthOut+1){1'b1}}, {(WidthOut-1){1'b0}}};

  logic [xw-1:0]      x;
  logic [yw-1:0]      y;
  logic [sw-1:0]      sx, sy, sx_cur, sy_cur;
  logic               in_fire, x_end, y_end, win_ok, produce, is_last;
  logic [WidthIn-1:0] line_q [KernelWidth-1][LineWidthPx];
  logic [WidthIn-1:0] new_col [KernelWidth];
  logic [WidthIn-1:0] win [KernelWidth][KernelWidth];
  logic [WidthIn-1:0] nwin [KernelWidth][KernelWidth];
  logic signed [acc_w-1:0] acc [OutChannels];
  logic [OutChannels-1:0][WidthOut-1:0] res;

  function automatic logic signed [acc_w-1:0] w_ext(input logic [WeightWidth-1:0] w);
    return {{(acc_w-WeightWidth){w[WeightWidth-1]}}, w};
  endfunction

  function automatic logic signed [acc_w-1:0] px_ext(input logic [WidthIn-1:0] p);
    return {{(acc_w-WidthIn){1'b0}}, p};
  endfunction

  assign ready_o = ~valid_o | ready_i;
  assign in_fire = valid_i & ready_o;
  assign x_end   = (x == xw'(LineWidthPx - 1));
  assign y_end   = (y == yw'(LineCountPx - 1));
  assign win_ok  = (x >= xw'(KernelWidth - 1)) && (y >= yw'(KernelWidth - 1));
  // Stride phases restart where the window first becomes valid on each axis.
  assign sx_cur  = (x == xw'(KernelWidth - 1)) ? '0 : sx;
  assign sy_cur  = (y == yw'(KernelWidth - 1)) ? '0 : sy;
  assign produce = in_fire & win_ok & (sx_cur == '0) & (sy_cur == '0);
  assign is_last = (x == xw'(last_x)) && (y == yw'(last_y));

  // Row delay lines: line_q[j] output is the pixel j+1 lines above data_i.
  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      for (int j = 0; j < KernelWidth - 1; j++) begin
        line_q[j][0] <= (j == 0) ? data_i : line_q[j-1][LineWidthPx-1];
        for (int i = 1; i < LineWidthPx; i++) line_q[j][i] <= line_q[j][i-1];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < KernelWidth; r++) begin
      new_col[r] = (r == KernelWidth - 1) ? data_i : line_q[KernelWidth-2-r][LineWidthPx-1];
      for (int c = 0; c < KernelWidth - 1; c++) nwin[r][c] = win[r][c+1];
      nwin[r][KernelWidth-1] = new_col[r];
    end
  end

  // Sums use the post-shift window so the firing pixel is included.
  always_comb begin
    res = '0;
    for (int ch = 0; ch < OutChannels; ch++) begin
      acc[ch] = '0;
      for (int r = 0; r < KernelWidth; r++)
        for (int c = 0; c < KernelWidth; c++)
          acc[ch] = acc[ch] + w_ext(weights_i[ch][r*KernelWidth+c]) * px_ext(nwin[r][c]);
      if (Saturate != 0 && acc[ch] > sat_max)      res[ch] = sat_max[WidthOut-1:0];
      else if (Saturate != 0 && acc[ch] < sat_min) res[ch] = sat_min[WidthOut-1:0];
      else                                         res[ch] = acc[ch][WidthOut-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x  <= '0;
      y  <= '0;
      sx <= '0;
      sy <= '0;
      for (int r = 0; r < KernelWidth; r++)
        for (int c = 0; c < KernelWidth; c++) win[r][c] <= '0;
    end else if (in_fire) begin
      win <= nwin;
      sx  <= (sx_cur == sw'(Stride - 1)) ? '0 : sx_cur + 1'b1;
      x   <= x_end ? '0 : x + 1'b1;
      if (x_end) begin
        y  <= y_end ? '0 : y + 1'b1;
        sy <= (sy_cur == sw'(Stride - 1)) ? '0 : sy_cur + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      data_o  <= '0;
    end else begin
      if (ready_o) valid_o <= produce;
      if (produce) begin
        data_o <= res;
        last_o <= is_last;
      end
    end
  end
endmodule

// File: tb/tb_conv2d_strided_mc.sv
// Scoreboard bench for conv2d_strided_mc: five configurations fed the same pixel stream,
// expected results computed from a direct window model and compared as outputs appear.
module tb_conv2d_strided_mc;
  localparam int W = 8;
  localparam int H = 6;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic valid_i = 1'b0;
  logic [7:0] data_i = '0;
  logic ready_a_i = 1'b1;
  logic valid_g;

  logic [1:0][8:0][1:0] w_a, w_c;
  logic [0:0][8:0][1:0] w_one;
  logic rdy_a, rdy_b, rdy_c, rdy_d, rdy_e;
  logic valid_a, valid_b, valid_c, valid_d, valid_e;
  logic last_a, last_b, last_c, last_d, last_e;
  logic [1:0][31:0] data_a, data_c;
  logic [0:0][31:0] data_b;
  logic [0:0][3:0]  data_d, data_e;

  logic [7:0] img [H][W];
  int wt [3][9];
  exp_t qa[$], qb[$], qc[$], qd[$], qe[$];
  int checks = 0;
  int failures = 0;
  int cnt_a, cnt_b, lcnt_a, lcnt_b;

  always #5 clk = ~clk;
  assign valid_g = valid_i & rdy_a;

  conv2d_strided_mc #(.LineWidthPx(W), .LineCountPx(H), .WidthIn(1), .WidthOut(32), .KernelWidth(3),
    .WeightWidth(2), .OutChannels(2), .Stride(1), .Saturate(0)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(rdy_a), .data_i(data_i[0]),
    .weights_i(w_a), .valid_o(valid_a), .ready_i(ready_a_i), .data_o(data_a), .last_o(last_a));

  conv2d_strided_mc #(.LineWidthPx(W), .LineCountPx(H), .WidthIn(1), .WidthOut(32), .KernelWidth(3),
    .WeightWidth(2), .OutChannels(1), .Stride(2), .Saturate(0)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_g), .ready_o(rdy_b), .data_i(data_i[0]),
    .weights_i(w_one), .valid_o(valid_b), .ready_i(1'b1), .data_o(data_b), .last_o(last_b));

  conv2d_strided_mc #(.LineWidthPx(W), .LineCountPx(H), .WidthIn(8), .WidthOut(32), .KernelWidth(3),
    .WeightWidth(2), .OutChannels(2), .Stride(1), .Saturate(0)) dut_c (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_g), .ready_o(rdy_c), .data_i(data_i),
    .weights_i(w_c), .valid_o(valid_c), .ready_i(1'b1), .data_o(data_c), .last_o(last_c));

  conv2d_strided_mc #(.LineWidthPx(W), .LineCountPx(H), .WidthIn(1), .WidthOut(4), .KernelWidth(3),
    .WeightWidth(2), .OutChannels(1), .Stride(1), .Saturate(1)) dut_d (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_g), .ready_o(rdy_d), .data_i(data_i[0]),
    .weights_i(w_one), .valid_o(valid_d), .ready_i(1'b1), .data_o(data_d), .last_o(last_d));

  conv2d_strided_mc #(.LineWidthPx(W), .LineCountPx(H), .WidthIn(1), .WidthOut(4), .KernelWidth(3),
    .WeightWidth(2), .OutChannels(1), .Stride(1), .Saturate(0)) dut_e (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_g), .ready_o(rdy_e), .data_i(data_i[0]),
    .weights_i(w_one), .valid_o(valid_e), .ready_i(1'b1), .data_o(data_e), .last_o(last_e));

  // Window sum at output pixel (x,y); row 0 / column 0 are the oldest samples.
  function automatic int wsum(input int x, input int y, input int t, input bit wide);
    int s = 0;
    int p;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        p = wide ? int'(img[y-2+r][x-2+c]) : int'(img[y-2+r][x-2+c][0]);
        s += wt[t][r*3+c] * p;
      end
    return s;
  endfunction

  task automatic push_expected(input int x, input int y);
    int s;
    int sat;
    bit lst;
    if (x >= 2 && y >= 2) begin
      lst = (x == W - 1) && (y == H - 1);
      qa.push_back('{d0: 32'(wsum(x, y, 0, 0)), d1: 32'(wsum(x, y, 1, 0)), last: lst});
      qc.push_back('{d0: 32'(wsum(x, y, 0, 1)), d1: 32'(wsum(x, y, 2, 1)), last: lst});
      s = wsum(x, y, 0, 0);
      sat = (s > 7) ? 7 : ((s < -8) ? -8 : s);
      qd.push_back('{d0: 32'(sat), d1: 32'd0, last: lst});
      qe.push_back('{d0: 32'(s), d1: 32'd0, last: lst});
      if ((x - 2) % 2 == 0 && (y - 2) % 2 == 0)
        qb.push_back('{d0: 32'(s), d1: 32'd0,
                       last: (x == 2 + ((W - 3) / 2) * 2) && (y == 2 + ((H - 3) / 2) * 2)});
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_a && ready_a_i) begin
        checks++;
        if (qa.size() == 0) begin
          failures++;
          $display("FAIL a_unexpected_output got=%0d expected none", $signed(data_a[0]));
        end else begin
          e = qa.pop_front();
          cnt_a++;
          if (last_a) lcnt_a++;
          if ({data_a[0], data_a[1], last_a} !== {e.d0, e.d1, e.last}) begin
            failures++;
            $display("FAIL a_data got=%0d,%0d,last=%0b expected=%0d,%0d,last=%0b",
                     $signed(data_a[0]), $signed(data_a[1]), last_a, $signed(e.d0), $signed(e.d1), e.last);
          end
        end
      end
      if (valid_b) begin
        checks++;
        if (qb.size() == 0) begin
          failures++;
          $display("FAIL b_unexpected_output got=%0d expected none", $signed(data_b[0]));
        end else begin
          e = qb.pop_front();
          cnt_b++;
          if (last_b) lcnt_b++;
          if ({data_b[0], last_b} !== {e.d0, e.last}) begin
            failures++;
            $display("FAIL b_data got=%0d,last=%0b expected=%0d,last=%0b",
                     $signed(data_b[0]), last_b, $signed(e.d0), e.last);
          end
        end
      end
      if (valid_c) begin
        checks++;
        if (qc.size() == 0) begin
          failures++;
          $display("FAIL c_unexpected_output got=%0d expected none", $signed(data_c[0]));
        end else begin
          e = qc.pop_front();
          if ({data_c[0], data_c[1], last_c} !== {e.d0, e.d1, e.last}) begin
            failures++;
            $display("FAIL c_data got=%0d,%0d,last=%0b expected=%0d,%0d,last=%0b",
                     $signed(data_c[0]), $signed(data_c[1]), last_c, $signed(e.d0), $signed(e.d1), e.last);
          end
        end
      end
      if (valid_d) begin
        checks++;
        if (qd.size() == 0) begin
          failures++;
          $display("FAIL d_unexpected_output got=%0d expected none", $signed(data_d[0]));
        end else begin
          e = qd.pop_front();
          if ({data_d[0], last_d} !== {e.d0[3:0], e.last}) begin
            failures++;
            $display("FAIL d_sat_data got=%0d,last=%0b expected=%0d,last=%0b",
                     $signed(data_d[0]), last_d, $signed(e.d0[3:0]), e.last);
          end
        end
      end
      if (valid_e) begin
        checks++;
        if (qe.size() == 0) begin
          failures++;
          $display("FAIL e_unexpected_output got=%0d expected none", $signed(data_e[0]));
        end else begin
          e = qe.pop_front();
          if ({data_e[0], last_e} !== {e.d0[3:0], e.last}) begin
            failures++;
            $display("FAIL e_wrap_data got=%0d,last=%0b expected=%0d,last=%0b",
                     $signed(data_e[0]), last_e, $signed(e.d0[3:0]), e.last);
          end
        end
      end
    end
  endtask

  task automatic fill_img(input bit random);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = random ? 8'($urandom) : 8'd3;
  endtask

  // Sends npix pixels in raster order (wrapping frames); entered/left at posedge+1.
  task automatic send_pixels(input int npix);
    int n;
    for (int i = 0; i < npix; i++) begin
      data_i  = img[(i / W) % H][i % W];
      valid_i = 1'b1;
      n = 0;
      @(negedge clk);
      while (!rdy_a) begin
        n++;
        if (n > 200) begin
          $display("FAIL send_timeout pixel=%0d ready stayed 0 for %0d cycles", i, n);
          failures++;
          $fatal(1, "send timeout");
        end
        @(negedge clk);
      end
      push_expected(i % W, (i / W) % H);
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
  endtask

  task automatic drain_and_count(input string tag, input int exp_a, input int exp_b, input int exp_l);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({cnt_a, cnt_b, lcnt_a, lcnt_b} !== {exp_a, exp_b, exp_l, exp_l}) begin
      failures++;
      $display("FAIL %s_counts got a=%0d b=%0d lastA=%0d lastB=%0d expected a=%0d b=%0d last=%0d",
               tag, cnt_a, cnt_b, lcnt_a, lcnt_b, exp_a, exp_b, exp_l);
    end
    checks++;
    if (qa.size() + qb.size() + qc.size() + qd.size() + qe.size() != 0) begin
      failures++;
      $display("FAIL %s_pending got=%0d,%0d,%0d,%0d,%0d expected all 0",
               tag, qa.size(), qb.size(), qc.size(), qd.size(), qe.size());
    end
    cnt_a = 0; cnt_b = 0; lcnt_a = 0; lcnt_b = 0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({valid_a, last_a, data_a, rdy_a} !== {1'b0, 1'b0, 64'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_a got valid=%0b last=%0b data=%h ready=%0b expected 0 0 0 1",
               valid_a, last_a, data_a, rdy_a);
    end
    checks++;
    if ({valid_b, valid_c, valid_d, valid_e, data_d, data_e} !== 12'd0) begin
      failures++;
      $display("FAIL reset_others got valid=%0b%0b%0b%0b d=%h e=%h expected all 0",
               valid_b, valid_c, valid_d, valid_e, data_d, data_e);
    end
    @(posedge clk); #1;
    rst_i = 1'b0;
  endtask

  task automatic test_ones_frame();
    fill_img(1'b0);
    send_pixels(W * H);
    drain_and_count("ones", 24, 6, 1);
  endtask

  task automatic test_back_to_back();
    fill_img(1'b1);
    send_pixels(2 * W * H);
    drain_and_count("b2b", 48, 12, 2);
  endtask

  task automatic test_stall();
    logic [63:0] hold_d;
    logic        hold_l;
    fill_img(1'b0);
    fork
      send_pixels(W * H);
      begin
        int n = 0;
        do begin
          @(posedge clk); #1;
          n++;
        end while (!valid_a && n < 100);
        checks++;
        if (!valid_a) begin
          failures++;
          $display("FAIL stall_no_output got valid=0 expected 1 within 100 cycles");
        end
        ready_a_i = 1'b0;
        hold_d = data_a;
        hold_l = last_a;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          checks++;
          if ({rdy_a, valid_a, data_a, last_a} !== {1'b0, 1'b1, hold_d, hold_l}) begin
            failures++;
            $display("FAIL stall_hold cycle=%0d got ready=%0b valid=%0b data=%h expected 0 1 %h",
                     k, rdy_a, valid_a, data_a, hold_d);
          end
        end
        @(posedge clk); #1;
        ready_a_i = 1'b1;
      end
    join
    drain_and_count("stall", 24, 6, 1);
  endtask

  task automatic test_reset_midframe();
    fill_img(1'b1);
    send_pixels(21);
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    drain_and_count("pre_reset", 3, 2, 0);
    fill_img(1'b1);
    send_pixels(W * H);
    drain_and_count("post_reset", 24, 6, 1);
  endtask

  initial begin
    wt[0] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    wt[1] = '{1, -1, 0, -2, 1, 1, 0, -1, 1};
    wt[2] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1};
    for (int i = 0; i < 9; i++) begin
      w_a[0][i]   = 2'(wt[0][i]);
      w_a[1][i]   = 2'(wt[1][i]);
      w_c[0][i]   = 2'(wt[0][i]);
      w_c[1][i]   = 2'(wt[2][i]);
      w_one[0][i] = 2'(wt[0][i]);
    end
    cnt_a = 0; cnt_b = 0; lcnt_a = 0; lcnt_b = 0;
    fork
      monitor();
    join_none
    @(posedge clk); #1;
    test_reset();
    test_ones_frame();
    test_back_to_back();
    test_stall();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
